frame_disassembly: RTL and testbench
====================================

# frame_disassembly

Receive-side counterpart of the MHP frame transmitter. It consumes a byte stream of fixed 51-byte MHP frames, reassembles the header and payload fields, and recomputes the 16-bit shifted-sum checksum (SCS). It presents each completed frame on parallel outputs with a one-cycle good/bad status pulse. It sits between the byte-level link receiver and the frame consumer logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: inter-byte idle limit in cycles. Used only when `MHP_RX_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_rdata`  in  8  received byte.
- `i_rvalid`  in  1  `i_rdata` valid this cycle. No backpressure: the block accepts every valid byte.
- `o_dst`  out  16  destination field.
- `o_src`  out  16  source field.
- `o_size`  out  16  size field.
- `o_dir`  out  1  direction bit.
- `o_type`  out  7  frame type.
- `o_payload`  out  336  payload; byte 7 of the frame lands in `[7:0]`.
- `o_valid`  out  1  one-cycle pulse: frame complete, SCS matched.
- `o_scs_err`  out  1  one-cycle pulse: frame complete, SCS mismatch.
- `o_abort`  out  1  one-cycle pulse: frame discarded on timeout. Tied 0 when the macro is undefined.

## Operation
- Wire byte order, index i = 0..50:
  - 0–1: dst, LSB first.
  - 2–3: src, LSB first.
  - 4–5: size, LSB first.
  - 6: {dir, type[6:0]}, with dir in bit 7.
  - 7–48: payload, LSB byte first.
  - 49: SCS[15:8].
  - 50: SCS[7:0].
- SCS definition: sum over i = 0..48 of (b_i << (i mod 4)), taken modulo 2^16. Each term is 16 bits wide before it is added.
- State machine:
  - IDLE: byte counter = 0, accumulator = 0. A valid byte is stored as byte 0; the counter goes to 1 and the state goes to RECV.
  - RECV: each valid byte is stored at index = counter, and the counter increments. Bytes 0–48 feed the accumulator. Bytes 49–50 are captured as the received SCS.
  - On accepting byte 50: compare the computed SCS with the received SCS and latch the parallel outputs. Return to IDLE in the same cycle.
- Output field registers update on every completed frame, good or bad. They hold their value until the next completed frame.
- `i_rvalid` low in RECV holds all state. Gaps between bytes of any length are legal unless the timeout is enabled.
- Frames may arrive back-to-back: a valid byte in the cycle after byte 50 is byte 0 of the next frame.
- The size field is not checked against the payload length. The consumer interprets it.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, accumulator 0. Reset takes effect immediately and asynchronously, even mid-frame; the partial frame is lost with no status pulse.
- Latency: byte 50 accepted on edge N; fields and the `o_valid`/`o_scs_err` pulse are visible after edge N+1, for exactly one cycle.
- `o_valid` and `o_scs_err` are mutually exclusive, and never both high in the same cycle as `o_abort`.
- Minimum frame duration is 51 cycles. At most one status pulse occurs per 51 accepted bytes.
- Counter range is 0..50. It never wraps past 50.

## Configuration
- `MHP_RX_TIMEOUT_EN` defined:
  - In RECV, an idle counter increments on each cycle with `i_rvalid` = 0 and clears on each accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, the block pulses `o_abort` for one cycle, discards the partial frame and returns to IDLE.
  - Output fields are not updated on an abort.
  - A byte arriving in the same cycle the limit is reached is accepted, and no abort occurs.
- `MHP_RX_TIMEOUT_EN` undefined: no idle counter, `o_abort` = 0, and the block waits indefinitely.

## Structure
- Shared package `mhp_pkg` holds:
  - `MHP_FRAME_LEN` = 51, `MHP_PAYLOAD_BYTES` = 42, `MHP_SCS_FIRST` = 49.
  - Field byte-offset constants.
  - The state enum.
  - The transmitter must use the same package.
- Sub-module `mhp_scs_accum`: clear, byte strobe, 8-bit data, and 2-bit shift index in; 16-bit running sum out. The transmitter reuses it.

## Test plan
- All-zero 51-byte frame, back-to-back bytes -> `o_valid` = 1 one cycle after byte 50, all fields 0, `o_scs_err` = 0.
- Byte0 = 0x01, all others 0, bytes 49/50 = 0x00/0x01 -> `o_valid`, `o_dst` = 0x0001, SCS = 0x0001.
- Same frame but byte 50 = 0x02 -> `o_scs_err` pulse; fields still updated, `o_dst` = 0x0001.
- Byte 6 = 0xA5 with a correct SCS -> `o_dir` = 1, `o_type` = 0x25. Random 2–5 cycle gaps between bytes give identical results.
- Two frames back-to-back with no idle cycle -> two status pulses exactly 51 cycles apart.
- With the macro defined and `TIMEOUT_CYCLES` = 8: stop after byte 20 for 8 cycles -> `o_abort` pulse, fields unchanged; the next full frame decodes correctly. Assert `rst_n` low mid-frame -> all outputs 0 at once and no pulses.

Source files
------------

// File: rtl/mhp_pkg.sv
// Shared MHP frame constants, field offsets and receive state encoding.
// Used by both the MHP frame transmitter and frame_disassembly.
package mhp_pkg;

  localparam int unsigned MHP_FRAME_LEN     = 51;
  localparam int unsigned MHP_PAYLOAD_BYTES = 42;
  localparam int unsigned MHP_SCS_FIRST     = 49;
  localparam int unsigned MHP_CNT_W         = 6;

  localparam int unsigned MHP_OFF_DST     = 0;
  localparam int unsigned MHP_OFF_SRC     = 2;
  localparam int unsigned MHP_OFF_SIZE    = 4;
  localparam int unsigned MHP_OFF_DIRTYPE = 6;
  localparam int unsigned MHP_OFF_PAYLOAD = 7;

  typedef enum logic {
    MHP_IDLE = 1'b0,
    MHP_RECV = 1'b1
  } mhp_state_e;

endpackage

// File: rtl/mhp_scs_accum.sv
// Running shifted-sum checksum: sum += data << shift on each strobe.
// A strobe together with clr restarts the sum at the new term.
module mhp_scs_accum (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        stb,
  input  logic [7:0]  data,
  input  logic [1:0]  shift,
  output logic [15:0] sum
);

  logic [15:0] term_c;

  assign term_c = 16'(data) << shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 16'd0;
    end else if (stb) begin
      sum <= (clr ? 16'd0 : sum) + term_c;
    end else if (clr) begin
      sum <= 16'd0;
    end
  end

endmodule

// File: rtl/frame_disassembly.sv
// Receives 51-byte MHP frames, rebuilds the fields and checks the SCS.
// Optional inter-byte timeout enabled by defining MHP_RX_TIMEOUT_EN.
module frame_disassembly
  import mhp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   i_rdata,
  input  logic         i_rvalid,
  output logic [15:0]  o_dst,
  output logic [15:0]  o_src,
  output logic [15:0]  o_size,
  output logic         o_dir,
  output logic [6:0]   o_type,
  output logic [335:0] o_payload,
  output logic         o_valid,
  output logic         o_scs_err,
  output logic         o_abort
);

  mhp_state_e                        state_q, state_d;
  logic [MHP_CNT_W-1:0]              cnt_q;
  logic [MHP_SCS_FIRST-1:0][7:0]     frame_q;
  logic [7:0]                        scs_hi_q;
  logic                              done_q;
  logic                              match_q;
  logic [15:0]                       sum;
  logic                              last_c;
  logic                              accum_c;
  logic                              timeout_c;

  assign last_c  = (state_q == MHP_RECV) && i_rvalid &&
                   (cnt_q == MHP_CNT_W'(MHP_FRAME_LEN - 1));
  assign accum_c = i_rvalid && (cnt_q < MHP_CNT_W'(MHP_SCS_FIRST));

  mhp_scs_accum u_scs (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == MHP_IDLE),
    .stb   (accum_c),
    .data  (i_rdata),
    .shift (cnt_q[1:0]),
    .sum   (sum)
  );

`ifdef MHP_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IDLE_W-1:0] idle_q;

  // Limit is reached on the TIMEOUT_CYCLES-th consecutive idle cycle
  assign timeout_c = (state_q == MHP_RECV) && !i_rvalid &&
                     (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else if ((state_q != MHP_RECV) || i_rvalid || timeout_c) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IDLE_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MHP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MHP_IDLE: if (i_rvalid) state_d = MHP_RECV;
      MHP_RECV: if (last_c || timeout_c) state_d = MHP_IDLE;
      default:  state_d = MHP_IDLE;
    endcase
  end

  // Byte capture; the SCS comparison is registered and published a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      frame_q  <= '0;
      scs_hi_q <= 8'd0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      done_q <= last_c;
      if (last_c) match_q <= (sum == {scs_hi_q, i_rdata});
      if (timeout_c) begin
        cnt_q <= '0;
      end else if (i_rvalid) begin
        cnt_q <= last_c ? '0 : cnt_q + MHP_CNT_W'(1);
        if (cnt_q < MHP_CNT_W'(MHP_SCS_FIRST)) begin
          frame_q[cnt_q] <= i_rdata;
        end else if (cnt_q == MHP_CNT_W'(MHP_SCS_FIRST)) begin
          scs_hi_q <= i_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_dst     <= 16'd0;
      o_src     <= 16'd0;
      o_size    <= 16'd0;
      o_dir     <= 1'b0;
      o_type    <= 7'd0;
      o_payload <= '0;
      o_valid   <= 1'b0;
      o_scs_err <= 1'b0;
      o_abort   <= 1'b0;
    end else begin
      o_valid   <= done_q && match_q;
      o_scs_err <= done_q && !match_q;
      o_abort   <= timeout_c;
      if (done_q) begin
        o_dst     <= {frame_q[MHP_OFF_DST + 1],  frame_q[MHP_OFF_DST]};
        o_src     <= {frame_q[MHP_OFF_SRC + 1],  frame_q[MHP_OFF_SRC]};
        o_size    <= {frame_q[MHP_OFF_SIZE + 1], frame_q[MHP_OFF_SIZE]};
        o_dir     <= frame_q[MHP_OFF_DIRTYPE][7];
        o_type    <= frame_q[MHP_OFF_DIRTYPE][6:0];
        o_payload <= frame_q[MHP_OFF_PAYLOAD +: MHP_PAYLOAD_BYTES];
      end
    end
  end

endmodule

// File: tb/tb_frame_disassembly.sv
// Scoreboard bench for frame_disassembly; define MHP_RX_TIMEOUT_EN to
// exercise the timeout abort path (DUT built with TIMEOUT_CYCLES = 8).
module tb_frame_disassembly;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rdata = 8'd0;
  logic         rvalid = 1'b0;
  logic [15:0]  dst, src, size;
  logic         dir;
  logic [6:0]   typ;
  logic [335:0] payload;
  logic         valid, scs_err, abort_p;

  frame_disassembly #(.TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rdata   (rdata),
    .i_rvalid  (rvalid),
    .o_dst     (dst),
    .o_src     (src),
    .o_size    (size),
    .o_dir     (dir),
    .o_type    (typ),
    .o_payload (payload),
    .o_valid   (valid),
    .o_scs_err (scs_err),
    .o_abort   (abort_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;   // 0 good, 1 scs error, 2 abort
    int           neg;    // expected negedge index, -1 = don't care
    logic [15:0]  dst, src, size;
    logic         dir;
    logic [6:0]   typ;
    logic [335:0] pl;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_fields;
  int         errors = 0;
  int         checks = 0;
  int         negcnt = 0;
  logic [7:0] fr [51];

  task automatic chk(input string name, input logic [335:0] act, input logic [335:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] scs_of();
    int s = 0;
    for (int i = 0; i < 49; i++) s += int'(fr[i]) * (1 << (i % 4));
    return 16'(s % 65536);
  endfunction

  task automatic set_scs();
    logic [15:0] s;
    s = scs_of();
    fr[49] = s[15:8];
    fr[50] = s[7:0];
  endtask

  task automatic push_frame();
    exp_t e;
    e.kind = ({fr[49], fr[50]} == scs_of()) ? 0 : 1;
    e.neg  = negcnt + 3;
    e.dst  = {fr[1], fr[0]};
    e.src  = {fr[3], fr[2]};
    e.size = {fr[5], fr[4]};
    e.dir  = fr[6][7];
    e.typ  = fr[6][6:0];
    e.pl   = '0;
    for (int k = 0; k < 42; k++) e.pl[k*8 +: 8] = fr[7 + k];
    last_fields = e;
    exp_q.push_back(e);
  endtask

  task automatic push_abort();
    exp_t e;
    e      = last_fields;
    e.kind = 2;
    e.neg  = -1;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; sends bytes [from..to] with random gaps
  task automatic send_range(input int from, input int to, input int gmin, input int gmax);
    int gap;
    for (int i = from; i <= to; i++) begin
      if (i == 50) push_frame();
      rdata  = fr[i];
      rvalid = 1'b1;
      @(posedge clk); #1;
      rvalid = 1'b0;
      gap = (gmax > 0) ? int'($urandom_range(gmax, gmin)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 51; i++) fr[i] = 8'd0;
  endtask

  task automatic rand_frame(input bit corrupt);
    for (int i = 0; i < 49; i++) fr[i] = 8'($urandom);
    set_scs();
    if (corrupt) fr[50] = fr[50] ^ 8'(1 << $urandom_range(7, 0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: pop and compare on every status pulse
  always @(negedge clk) begin
    exp_t e;
    int   kind;
    negcnt++;
    if (rst_n && (valid || scs_err || abort_p)) begin
      checks++;
      if ($countones({valid, scs_err, abort_p}) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: got v=%0b e=%0b a=%0b", valid, scs_err, abort_p);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got v=%0b e=%0b a=%0b expected none", valid, scs_err, abort_p);
      end else begin
        e = exp_q.pop_front();
        kind = valid ? 0 : (scs_err ? 1 : 2);
        chk("status_kind", 336'(kind), 336'(e.kind));
        if (e.neg >= 0) chk("pulse_cycle", 336'(negcnt), 336'(e.neg));
        chk("dst_src_size", {dst, src, size}, {e.dst, e.src, e.size});
        chk("dir_type", {dir, typ}, {e.dir, e.typ});
        chk("payload", payload, e.pl);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    last_fields = '{kind: 0, neg: -1, dst: 16'd0, src: 16'd0, size: 16'd0,
                    dir: 1'b0, typ: 7'd0, pl: '0};
    clear_frame();
    #22;
    chk("reset_outputs", {dst, src, size, dir, typ, payload, valid, scs_err, abort_p}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero frame, back-to-back bytes
    clear_frame();
    send_range(0, 50, 0, 0);
    idle(3);

    // dst = 1 with SCS 0x0001, then same frame with a bad SCS
    clear_frame();
    fr[0] = 8'h01; fr[49] = 8'h00; fr[50] = 8'h01;
    send_range(0, 50, 0, 0);
    idle(2);
    fr[50] = 8'h02;
    send_range(0, 50, 0, 0);
    idle(3);

    // dir/type byte, back-to-back then with 2..5 cycle gaps
    clear_frame();
    fr[6] = 8'hA5;
    set_scs();
    send_range(0, 50, 0, 0);
    idle(2);
    send_range(0, 50, 2, 5);
    idle(3);

    // Two random frames with no idle cycle between them
    rand_frame(1'b0);
    send_range(0, 50, 0, 0);
    rand_frame(1'b0);
    send_range(0, 50, 0, 0);
    idle(3);

    // Random traffic, about a quarter with corrupted SCS
    for (int n = 0; n < 16; n++) begin
      rand_frame($urandom_range(3, 0) == 0);
      send_range(0, 50, 0, 3);
      idle(int'($urandom_range(2, 0)));
    end
    idle(3);

    // Stall after byte 20
    rand_frame(1'b0);
`ifdef MHP_RX_TIMEOUT_EN
    push_abort();
    send_range(0, 20, 0, 0);
    idle(14);
    rand_frame(1'b0);
    send_range(0, 50, 0, 2);
`else
    send_range(0, 20, 0, 0);
    idle(40);
    send_range(21, 50, 0, 0);
`endif
    idle(3);

    // Reset mid-frame: outputs clear at once and the partial frame is lost
    rand_frame(1'b0);
    send_range(0, 10, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {dst, src, size, dir, typ, payload, valid, scs_err, abort_p}, '0);
    last_fields.dst = 16'd0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    rand_frame(1'b0);
    send_range(0, 50, 0, 1);
    idle(6);

    chk("queue_empty", 336'(exp_q.size()), 336'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
